// File: rtl/seq_array_divider.sv
// Sequential restoring divider: 2*DW-bit dividend by DW-bit divisor, one quotient bit per clock.
// Inverse of the array multiplier; start/busy/done handshake with held results.
module seq_array_divider #(
    parameter int DW = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2*DW-1:0] dividend,
    input  logic [DW-1:0]   divisor,
    output logic            busy,
    output logic            done,
    output logic [2*DW-1:0] quotient,
    output logic [DW-1:0]   remainder,
    output logic            div_by_zero
);
    localparam int QW = 2 * DW;
    localparam int CW = $clog2(QW);

    typedef enum logic [1:0] {IDLE, CALC, ZERO, DONE} state_t;

    state_t        state;
    logic [QW-1:0] dvd;
    logic [DW-1:0] dvs;
    logic [DW:0]   part;
    logic [CW-1:0] cnt;
    logic [DW:0]   shifted;
    logic [DW:0]   trial;
    logic          qbit;
    logic [DW:0]   part_next;

    // Partial remainder stays below the divisor, so bit DW of the trial is its sign.
    always_comb begin
        shifted   = {part[DW-1:0], dvd[QW-1]};
        trial     = shifted - {1'b0, dvs};
        qbit      = ~trial[DW];
        part_next = qbit ? trial : shifted;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            dvd         <= '0;
            dvs         <= '0;
            part        <= '0;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        dvd         <= dividend;
                        dvs         <= divisor;
                        part        <= '0;
                        cnt         <= '0;
                        div_by_zero <= 1'b0;
                        busy        <= 1'b1;
                        state       <= (divisor == '0) ? ZERO : CALC;
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    // Quotient bits shift into the vacated low end of the dividend register.
                    part <= part_next;
                    dvd  <= {dvd[QW-2:0], qbit};
                    cnt  <= cnt + CW'(1);
                    if (cnt == CW'(QW - 1)) begin
                        quotient  <= {dvd[QW-2:0], qbit};
                        remainder <= part_next[DW-1:0];
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
                ZERO: begin
                    quotient    <= '1;
                    remainder   <= '0;
                    div_by_zero <= 1'b1;
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    state       <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_array_divider.sv
// Self-checking bench for seq_array_divider: vector table, corner sequences,
// exhaustive sweep, multiplier round trip and random ops against an arithmetic model.
module tb_seq_array_divider;
    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    int checks = 0;
    int failures = 0;

    // Results of the last operation run by do_op
    logic [7:0] rq;
    logic [3:0] rr;
    logic       rz;
    int         rlat;
    int         rbusy;

    seq_array_divider #(.DW(4)) dut (
        .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [3:0] b;
        logic [7:0] q;
        logic [3:0] r;
        logic       z;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=no_done expected=done", name);
    endtask

    // Reference: plain unsigned division, all-ones quotient on divide by zero.
    function automatic logic [12:0] ref_div(input logic [7:0] a, input logic [3:0] b);
        int q, r;
        if (b == 0) return {8'hFF, 4'h0, 1'b1};
        q = int'(a) / int'(b);
        r = int'(a) % int'(b);
        return {q[7:0], r[3:0], 1'b0};
    endfunction

    function automatic int exp_lat(input logic [3:0] b);
        return (b == 0) ? 1 : 8;
    endfunction

    // Drives operands with start=1 now (away from an edge); the next edge is the accept edge.
    // rlat = edges after the accept edge until done is seen; rbusy = cycles busy observed high.
    task automatic do_op(input logic [7:0] a, input logic [3:0] b, input bit keep);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk); #1;
        if (!keep) start = 1'b0;
        rbusy = busy ? 1 : 0;
        rlat  = 0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            if (done) begin
                rlat = k;
                break;
            end
            if (busy) rbusy++;
        end
        if (rlat == 0) timeout_fail("done_timeout");
        rq = quotient;
        rr = remainder;
        rz = div_by_zero;
    endtask

    vec_t tbl[11];
    logic [12:0] m;
    int cnt;
    int prev_done_t;

    initial begin
        tbl[0]  = '{8'd120, 4'd12, 8'd10,  4'd0, 1'b0};
        tbl[1]  = '{8'd156, 4'd12, 8'd13,  4'd0, 1'b0};
        tbl[2]  = '{8'd200, 4'd7,  8'd28,  4'd4, 1'b0};
        tbl[3]  = '{8'd255, 4'd1,  8'd255, 4'd0, 1'b0};
        tbl[4]  = '{8'd15,  4'd15, 8'd1,   4'd0, 1'b0};
        tbl[5]  = '{8'd9,   4'd10, 8'd0,   4'd9, 1'b0};
        tbl[6]  = '{8'd5,   4'd0,  8'hFF,  4'd0, 1'b1};
        tbl[7]  = '{8'd143, 4'd11, 8'd13,  4'd0, 1'b0};
        tbl[8]  = '{8'd0,   4'd7,  8'd0,   4'd0, 1'b0};
        tbl[9]  = '{8'd255, 4'd15, 8'd17,  4'd0, 1'b0};
        tbl[10] = '{8'd254, 4'd13, 8'd19,  4'd7, 1'b0};

        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_quotient", quotient, 0);
        chk("reset_remainder", remainder, 0);
        chk("reset_dbz", div_by_zero, 0);

        // Table run with start held high: each op accepted at the DONE cycle of the previous one.
        prev_done_t = -1;
        for (int i = 0; i < 11; i++) begin
            do_op(tbl[i].a, tbl[i].b, 1'b1);
            chk($sformatf("tbl%0d_q", i), rq, tbl[i].q);
            chk($sformatf("tbl%0d_r", i), rr, tbl[i].r);
            chk($sformatf("tbl%0d_dbz", i), rz, tbl[i].z);
            chk($sformatf("tbl%0d_latency", i), rlat, exp_lat(tbl[i].b));
            if (tbl[i].b != 0) chk($sformatf("tbl%0d_busy_cycles", i), rbusy, 8);
            if (i > 0) chk($sformatf("tbl%0d_period", i), int'($time / 10) - prev_done_t,
                           exp_lat(tbl[i].b) + 1);
            prev_done_t = int'($time / 10);
        end
        start = 1'b0;
        @(posedge clk); #1;
        chk("done_one_cycle", done, 0);
        chk("held_quotient", quotient, 19);
        chk("held_remainder", remainder, 7);

        // Start while busy is ignored.
        @(negedge clk);
        dividend = 8'd100; divisor = 4'd3; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1 dividend = 8'd50; divisor = 4'd5; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        rlat = 0;
        for (int k = 5; k <= 30; k++) begin
            @(posedge clk); #1;
            if (done) begin rlat = k; break; end
        end
        if (rlat == 0) timeout_fail("ignore_done_timeout");
        chk("ignore_latency", rlat, 8);
        chk("ignore_q", quotient, 33);
        chk("ignore_r", remainder, 1);
        cnt = 0;
        repeat (15) begin @(posedge clk); #1; if (done) cnt++; end
        chk("ignore_no_second_done", cnt, 0);
        chk("ignore_idle_busy", busy, 0);

        // Reset aborts an operation in flight.
        @(negedge clk);
        dividend = 8'd180; divisor = 4'd9; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_q", quotient, 0);
        chk("abort_r", remainder, 0);
        chk("abort_dbz", div_by_zero, 0);
        cnt = 0;
        repeat (15) begin @(posedge clk); #1; if (done) cnt++; end
        chk("abort_no_done", cnt, 0);
        do_op(8'd180, 4'd9, 1'b0);
        chk("after_abort_q", rq, 20);
        chk("after_abort_r", rr, 0);
        chk("after_abort_dbz", rz, 0);

        // Exhaustive sweep: model match, reconstruction invariant and remainder bound.
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 16; b++) begin
                do_op(8'(a), 4'(b), 1'b0);
                m = ref_div(8'(a), 4'(b));
                chk("sweep_q", rq, m[12:5]);
                chk("sweep_r", rr, m[4:1]);
                chk("sweep_dbz", rz, m[0]);
                if (b != 0) begin
                    chk("sweep_invariant", int'(rq) * b + int'(rr), a);
                    chk("sweep_rem_bound", (int'(rr) < b) ? 1 : 0, 1);
                end
            end
        end

        // Round trip with the 4x4 multiplier: (inp1*inp2)/inp2 == inp1.
        for (int x = 0; x < 16; x++) begin
            for (int y = 1; y < 16; y++) begin
                do_op(8'(x * y), 4'(y), 1'b0);
                chk("roundtrip_q", rq, x);
                chk("roundtrip_r", rr, 0);
            end
        end

        // Random ops with random idle gaps.
        for (int i = 0; i < 200; i++) begin
            logic [7:0] ra;
            logic [3:0] rb;
            ra = 8'($urandom_range(0, 255));
            rb = 4'($urandom_range(0, 15));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            do_op(ra, rb, 1'b0);
            m = ref_div(ra, rb);
            chk("rand_q", rq, m[12:5]);
            chk("rand_r", rr, m[4:1]);
            chk("rand_dbz", rz, m[0]);
            chk("rand_latency", rlat, exp_lat(rb));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
